// File: rtl/sd_card_dat.sv
// Card-side SD 4-bit DAT engine: sends one 512-byte sector with per-line CRC16,
// or receives one, checks the CRCs and answers with a CRC status token plus busy.
module sd_card_dat #(
    parameter int NAC_CYCLES  = 2,
    parameter int BUSY_CYCLES = 8,
    parameter int WR_TIMEOUT  = 1000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sdclk,
    input  logic [3:0] i_sddat_in,
    output logic [3:0] o_sddat_out,
    output logic       o_sddat_oe,
    input  logic       i_rd_start,
    input  logic       i_wr_start,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_crc_ok,
    output logic [8:0] o_buf_addr,
    output logic       o_buf_rd,
    input  logic [7:0] i_buf_rdata,
    output logic       o_buf_wr,
    output logic [7:0] o_buf_wdata
);

    typedef enum logic [3:0] {
        IDLE, R_NAC, R_START, R_DATA, R_CRC, R_END,
        W_WAIT, W_DATA, W_CRC, W_END, W_TOK, W_BUSY
    } state_t;

    localparam int TW = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT + 1) : 1;

    state_t        r_state;
    logic          r_sclk_s1;
    logic          r_sclk_s2;
    logic [3:0]    r_dout;
    logic          r_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_crc_ok;
    logic [8:0]    r_addr;
    logic          r_buf_rd;
    logic          r_buf_wr;
    logic          r_rd_d;
    logic [7:0]    r_wdata;
    logic [7:0]    r_hold;
    logic [3:0]    r_hi;
    logic [9:0]    r_nib;
    logic [3:0]    r_cidx;
    logic [15:0]   r_cnt;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_crc [4];
    logic          r_crc_bad;
    logic          w_rise;
    logic          w_fall;
    logic [3:0]    w_tx_nib;
    logic [3:0]    w_crc_bits;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign w_rise   = r_sclk_s1 & ~r_sclk_s2;
    assign w_fall   = ~r_sclk_s1 & r_sclk_s2;
    assign w_tx_nib = r_nib[0] ? r_hold[3:0] : r_hold[7:4];

    assign o_sddat_out = r_dout;
    assign o_sddat_oe  = r_oe;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_crc_ok    = r_crc_ok;
    assign o_buf_addr  = r_addr;
    assign o_buf_rd    = r_buf_rd;
    assign o_buf_wr    = r_buf_wr;
    assign o_buf_wdata = r_wdata;

    always_comb begin
        w_crc_bits = 4'h0;
        for (int i = 0; i < 4; i++) begin
            w_crc_bits[i] = r_crc[i][4'd15 - r_cidx];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= i_sdclk;
            r_sclk_s2 <= r_sclk_s1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_dout    <= 4'hF;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_crc_ok  <= 1'b0;
            r_addr    <= 9'd0;
            r_buf_rd  <= 1'b0;
            r_buf_wr  <= 1'b0;
            r_rd_d    <= 1'b0;
            r_wdata   <= 8'h00;
            r_hold    <= 8'h00;
            r_hi      <= 4'h0;
            r_nib     <= 10'd0;
            r_cidx    <= 4'd0;
            r_cnt     <= 16'd0;
            r_tmo     <= '0;
            r_crc_bad <= 1'b0;
            for (int i = 0; i < 4; i++) r_crc[i] <= 16'h0000;
        end else begin
            r_buf_rd <= 1'b0;
            r_buf_wr <= 1'b0;
            r_done   <= 1'b0;
            r_rd_d   <= r_buf_rd;
            // buffer read data is valid one clk after the request
            if (r_rd_d) r_hold <= i_buf_rdata;
            if (i_abort) begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
                r_dout  <= 4'hF;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_rd_start) begin
                            r_state  <= R_NAC;
                            r_busy   <= 1'b1;
                            r_cnt    <= 16'd0;
                            r_crc_ok <= 1'b0;
                            for (int i = 0; i < 4; i++) r_crc[i] <= 16'h0000;
                        end else if (i_wr_start) begin
                            r_state   <= W_WAIT;
                            r_busy    <= 1'b1;
                            r_tmo     <= '0;
                            r_crc_ok  <= 1'b0;
                            r_crc_bad <= 1'b0;
                            for (int i = 0; i < 4; i++) r_crc[i] <= 16'h0000;
                        end
                    end
                    R_NAC: if (w_fall) begin
                        if (r_cnt == 16'(NAC_CYCLES - 1)) r_state <= R_START;
                        else r_cnt <= r_cnt + 16'd1;
                    end
                    R_START: if (w_fall) begin
                        r_dout   <= 4'h0;
                        r_oe     <= 1'b1;
                        r_buf_rd <= 1'b1;
                        r_addr   <= 9'd0;
                        r_nib    <= 10'd0;
                        r_state  <= R_DATA;
                    end
                    R_DATA: if (w_fall) begin
                        r_dout <= w_tx_nib;
                        for (int i = 0; i < 4; i++) r_crc[i] <= crc16_step(r_crc[i], w_tx_nib[i]);
                        // next byte is fetched while the low nibble of this one goes out
                        if (r_nib[0] && (r_nib != 10'd1023)) begin
                            r_buf_rd <= 1'b1;
                            r_addr   <= r_nib[9:1] + 9'd1;
                        end
                        if (r_nib == 10'd1023) begin
                            r_state <= R_CRC;
                            r_cidx  <= 4'd0;
                        end
                        r_nib <= r_nib + 10'd1;
                    end
                    R_CRC: if (w_fall) begin
                        r_dout <= w_crc_bits;
                        if (r_cidx == 4'd15) begin
                            r_state <= R_END;
                            r_cnt   <= 16'd0;
                        end
                        r_cidx <= r_cidx + 4'd1;
                    end
                    R_END: if (w_fall) begin
                        if (r_cnt == 16'd0) begin
                            r_dout <= 4'hF;
                            r_cnt  <= 16'd1;
                        end else begin
                            r_oe    <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    W_WAIT: if (w_rise) begin
                        if (!i_sddat_in[0]) begin
                            r_state <= W_DATA;
                            r_nib   <= 10'd0;
                        end else if (r_tmo == TW'(WR_TIMEOUT - 1)) begin
                            r_done   <= 1'b1;
                            r_crc_ok <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    W_DATA: if (w_rise) begin
                        for (int i = 0; i < 4; i++) r_crc[i] <= crc16_step(r_crc[i], i_sddat_in[i]);
                        if (!r_nib[0]) begin
                            r_hi <= i_sddat_in;
                        end else begin
                            r_buf_wr <= 1'b1;
                            r_wdata  <= {r_hi, i_sddat_in};
                            r_addr   <= r_nib[9:1];
                        end
                        if (r_nib == 10'd1023) begin
                            r_state <= W_CRC;
                            r_cidx  <= 4'd0;
                        end
                        r_nib <= r_nib + 10'd1;
                    end
                    W_CRC: if (w_rise) begin
                        r_crc_bad <= r_crc_bad | (i_sddat_in != w_crc_bits);
                        if (r_cidx == 4'd15) r_state <= W_END;
                        r_cidx <= r_cidx + 4'd1;
                    end
                    W_END: if (w_rise) begin
                        r_state <= W_TOK;
                        r_cnt   <= 16'd0;
                    end
                    // DAT0 token: start, 3 status bits, end; then release on a bad CRC
                    W_TOK: if (w_fall) begin
                        r_oe  <= 1'b1;
                        r_cnt <= r_cnt + 16'd1;
                        case (r_cnt)
                            16'd0:   r_dout <= 4'b1110;
                            16'd1:   r_dout <= {3'b111, r_crc_bad};
                            16'd2:   r_dout <= {3'b111, ~r_crc_bad};
                            16'd3:   r_dout <= {3'b111, r_crc_bad};
                            16'd4: begin
                                r_dout <= 4'b1111;
                                if (!r_crc_bad) begin
                                    r_state <= W_BUSY;
                                    r_cnt   <= 16'd0;
                                end
                            end
                            default: begin
                                r_oe     <= 1'b0;
                                r_dout   <= 4'hF;
                                r_done   <= 1'b1;
                                r_crc_ok <= 1'b0;
                                r_busy   <= 1'b0;
                                r_state  <= IDLE;
                            end
                        endcase
                    end
                    W_BUSY: if (w_fall) begin
                        if (r_cnt == 16'(BUSY_CYCLES)) begin
                            r_oe     <= 1'b0;
                            r_dout   <= 4'hF;
                            r_done   <= 1'b1;
                            r_crc_ok <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_dout <= 4'b1110;
                            r_cnt  <= r_cnt + 16'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
